mc_control_unit: RTL

Multi-cycle control FSM for the simpleCPU datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath select and enable, including Se on the 16-to-32 immediate extender, ALU operation, register-file and memory strobes, and PC update. Handshakes with instruction/data memory through a single ready line. Sits between the IR/flag outputs and the datapath select/enable inputs.

---
 rtl/cpu_defs.sv | 31 +++
 rtl/mc_decode.sv | 49 ++++
 rtl/mc_control_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: opcode/function codes, ALU and PC-select codes, FSM states and instruction classes
package cpu_defs;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_MEM, S_MEM_RD, S_WB_LD, S_MEM_WR, S_EXE_BR, S_HALT
  } state_t;
  typedef enum logic [2:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_HALT, C_ILLEGAL
  } iclass_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational Op/Func decode into instruction class, extender mode and ALU controls
module mc_decode
  import cpu_defs::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [FN_W-1:0] i_func,
  output iclass_t         o_class,
  output logic            o_se,
  output logic [2:0]      o_alu_op,
  output logic            o_alu_src_b
);
  logic w_fn_ok;
  assign w_fn_ok = (i_func == FN_ADD) || (i_func == FN_SUB) || (i_func == FN_AND) ||
                   (i_func == FN_OR) || (i_func == FN_SLT);
  always_comb begin
    o_class  = C_ILLEGAL;
    o_alu_op = ALU_ADD;
    case (i_op)
      OP_RTYPE: begin
        o_class  = w_fn_ok ? C_ALU_R : C_ILLEGAL;
        o_alu_op = (i_func == FN_SUB) ? ALU_SUB : (i_func == FN_AND) ? ALU_AND :
                   (i_func == FN_OR) ? ALU_OR : (i_func == FN_SLT) ? ALU_SLT : ALU_ADD;
      end
      OP_ADDI: o_class = C_ALU_I;
      OP_ANDI: begin
        o_class  = C_ALU_I;
        o_alu_op = ALU_AND;
      end
      OP_ORI: begin
        o_class  = C_ALU_I;
        o_alu_op = ALU_OR;
      end
      OP_LW:   o_class = C_LOAD;
      OP_SW:   o_class = C_STORE;
      OP_BEQ: begin
        o_class  = C_BRANCH;
        o_alu_op = ALU_SUB;
      end
      OP_J:    o_class = C_JUMP;
      OP_HALT: o_class = C_HALT;
      default: o_class = C_ILLEGAL;
    endcase
  end
  assign o_se = (i_op == OP_ADDI) || (i_op == OP_LW) || (i_op == OP_SW) || (i_op == OP_BEQ);
  assign o_alu_src_b = (o_class == C_ALU_I) || (o_class == C_LOAD) || (o_class == C_STORE);
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle fetch/decode/execute/memory/writeback sequencer for the simpleCPU datapath
module mc_control_unit
  import cpu_defs::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] Op,
  input  logic [FN_W-1:0] Func,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            InsMemRd,
  output logic            IRWre,
  output logic            Se,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            MemRd,
  output logic            MemWr,
  output logic            RegWre,
  output logic            RegDst,
  output logic            WrSrc,
  output logic            PCWre,
  output logic [1:0]      PCSrc,
  output logic            halted,
  output logic            illegal,
  output logic [ST_W-1:0] state
);
  state_t     r_state, w_next;
  iclass_t    w_class;
  logic       w_se, w_alu_src_b, w_exe, w_id_skip;
  logic [2:0] w_alu_op;
  mc_decode #(.OP_W(OP_W), .FN_W(FN_W)) u_decode (
    .i_op        (Op),
    .i_func      (Func),
    .o_class     (w_class),
    .o_se        (w_se),
    .o_alu_op    (w_alu_op),
    .o_alu_src_b (w_alu_src_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:      w_next = mem_ready ? S_ID : S_IF;
      S_ID:      w_next = (w_class == C_ALU_R || w_class == C_ALU_I) ? S_EXE_AL :
                          (w_class == C_LOAD || w_class == C_STORE) ? S_EXE_MEM :
                          (w_class == C_BRANCH) ? S_EXE_BR :
                          (w_class == C_HALT) ? S_HALT : S_IF;
      S_EXE_AL:  w_next = S_WB_AL;
      S_EXE_MEM: w_next = (w_class == C_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = mem_ready ? S_WB_LD : S_MEM_RD;
      S_MEM_WR:  w_next = mem_ready ? S_IF : S_MEM_WR;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_IF;
    endcase
  end
  // ALU controls come from the decoder in every execute state and stay held through WB_AL
  assign w_exe = (r_state == S_EXE_AL) || (r_state == S_WB_AL) ||
                 (r_state == S_EXE_MEM) || (r_state == S_EXE_BR);
  assign w_id_skip = (r_state == S_ID) && (w_class == C_JUMP || w_class == C_ILLEGAL);
  assign InsMemRd = rst_n && (r_state == S_IF);
  assign IRWre    = InsMemRd && mem_ready;
  assign Se       = rst_n && w_se;
  assign ALUSrcB  = rst_n && w_exe && w_alu_src_b;
  assign ALUOp    = (rst_n && w_exe) ? w_alu_op : ALU_ADD;
  assign MemRd    = rst_n && (r_state == S_MEM_RD);
  assign MemWr    = rst_n && (r_state == S_MEM_WR);
  assign RegWre   = rst_n && (r_state == S_WB_AL || r_state == S_WB_LD);
  assign RegDst   = rst_n && (r_state == S_WB_AL) && (w_class == C_ALU_R);
  assign WrSrc    = rst_n && (r_state == S_WB_LD);
  assign PCWre    = rst_n && (r_state == S_WB_AL || r_state == S_WB_LD || r_state == S_EXE_BR ||
                              (r_state == S_MEM_WR && mem_ready) || w_id_skip);
  assign PCSrc    = !rst_n ? PC_SEQ :
                    (r_state == S_ID && w_class == C_JUMP) ? PC_JMP :
                    (r_state == S_EXE_BR && Zero) ? PC_BR : PC_SEQ;
  assign halted   = rst_n && (r_state == S_HALT);
  assign illegal  = rst_n && (r_state == S_ID) && (w_class == C_ILLEGAL);
  assign state    = rst_n ? r_state : S_IF;
endmodule
